subbytes_iter: RTL and testbench

//  Iterative AES SubBytes stage, directly upstream of ShiftRows/MixColumns in the round datapath.

---
 rtl/aes_pkg.sv | 18 +
 rtl/aes_sbox.sv | 32 +++
 rtl/subbytes_iter.sv | 128 ++++++++++++
 tb/tb_subbytes_iter.sv | 407 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_pkg.sv
// Shared AES definitions: FSM encoding, state geometry and byte indexing.
package aes_pkg;

  localparam int AES_BYTES   = 16;
  localparam int AES_STATE_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } aes_fsm_e;

  // Column-major byte position: column c, row r.
  function automatic int byte_idx(input int c, input int r);
    return 4 * c + r;
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward AES S-box, 256-entry lookup table.
module aes_sbox (
  input  logic [7:0] din,
  output logic [7:0] dout
);

  // Entry 0 occupies the most significant byte of the table.
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  logic [10:0] top_bit;

  assign top_bit = 11'd2047 - {din, 3'b000};
  assign dout    = SBOX_TABLE[top_bit -: 8];

endmodule

// File: rtl/subbytes_iter.sv
// Iterative AES SubBytes: BYTES_PER_CYCLE bytes per cycle in fixed ascending order.
// Optional scope trigger output enabled by defining SUBBYTES_TRIGGER_EN.
module subbytes_iter
  import aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] state_in,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] state_out,
`ifdef SUBBYTES_TRIGGER_EN
  output logic         busy,
  output logic         trig
`else
  output logic         busy
`endif
);

  localparam int NUM_STEPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W     = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
  localparam int SLICE_W   = 8 * BYTES_PER_CYCLE;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NUM_STEPS - 1);

  if (BYTES_PER_CYCLE != 1 && BYTES_PER_CYCLE != 2 && BYTES_PER_CYCLE != 4 &&
      BYTES_PER_CYCLE != 8 && BYTES_PER_CYCLE != 16) begin : g_bad_bpc
    $error("subbytes_iter: BYTES_PER_CYCLE must be 1, 2, 4, 8 or 16");
  end

  aes_fsm_e               fsm_q, fsm_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [AES_STATE_W-1:0] data_q, data_d;
  logic [SLICE_W-1:0]     slice_in;
  logic [SLICE_W-1:0]     slice_sub;
  logic                   accept;

  assign accept = (fsm_q == ST_IDLE) && in_valid;

  if (NUM_STEPS == 1) begin : g_one_step
    assign slice_in = data_q;
  end else begin : g_multi_step
    assign slice_in = data_q[cnt_q*SLICE_W +: SLICE_W];
  end

  for (genvar l = 0; l < BYTES_PER_CYCLE; l++) begin : g_sbox
    aes_sbox u_sbox (
      .din  (slice_in[8*l +: 8]),
      .dout (slice_sub[8*l +: 8])
    );
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= ST_IDLE;
      cnt_q  <= '0;
      data_q <= '0;
    end else begin
      fsm_q  <= fsm_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
    end
  end

  // Next-state logic
  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      ST_IDLE: if (in_valid)          fsm_d = ST_BUSY;
      ST_BUSY: if (cnt_q == CNT_LAST) fsm_d = ST_DONE;
      ST_DONE: if (out_ready)         fsm_d = ST_IDLE;
      default:                        fsm_d = ST_IDLE;
    endcase
  end

  // Step counter and byte write-back; only the bytes of the current step change.
  always_comb begin
    cnt_d  = cnt_q;
    data_d = data_q;
    if (accept) begin
      cnt_d  = '0;
      data_d = state_in;
    end else if (fsm_q == ST_BUSY) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + 1'b1;
      for (int c = 0; c < 4; c++) begin
        for (int r = 0; r < 4; r++) begin
          if (cnt_q == CNT_W'(byte_idx(c, r) / BYTES_PER_CYCLE))
            data_d[8*byte_idx(c, r) +: 8] =
              slice_sub[8*(byte_idx(c, r) % BYTES_PER_CYCLE) +: 8];
        end
      end
    end
  end

  // Outputs decoded from registered state only
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (fsm_q)
      ST_IDLE: in_ready  = 1'b1;
      ST_BUSY: busy      = 1'b1;
      ST_DONE: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign state_out = data_q;

`ifdef SUBBYTES_TRIGGER_EN
  logic trig_q, trig_d;

  // High for the single BUSY cycle in which byte 0 is substituted.
  assign trig_d = accept;

  always_ff @(posedge clk) begin
    if (rst) trig_q <= 1'b0;
    else     trig_q <= trig_d;
  end

  assign trig = trig_q;
`endif

endmodule

// File: tb/tb_subbytes_iter.sv
// Self-checking bench for subbytes_iter; four instances with BYTES_PER_CYCLE 4, 1, 2, 16.
`timescale 1ns/1ps
module tb_subbytes_iter;

  localparam logic [127:0] FIPS_IN  = 128'h0848f8e92a8dc69a2be2f4a0bee33d19;
  localparam logic [127:0] FIPS_OUT = 128'h3052411ee55db4b8f198bfe0ae1127d4;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] state_in;
  logic [3:0]   in_valid_v, in_ready_v, out_valid_v, out_ready_v, busy_v;
  logic [127:0] state_out_v [4];
`ifdef SUBBYTES_TRIGGER_EN
  logic [3:0]   trig_v;
`endif
  int           n_cmp = 0;
  int           n_err = 0;
  logic [7:0]   sbox_ref [256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int P = (g == 0) ? 4 : (g == 1) ? 1 : (g == 2) ? 2 : 16;
    subbytes_iter #(.BYTES_PER_CYCLE(P)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_v[g]),
      .in_ready  (in_ready_v[g]),
      .state_in  (state_in),
      .out_valid (out_valid_v[g]),
      .out_ready (out_ready_v[g]),
      .state_out (state_out_v[g]),
`ifdef SUBBYTES_TRIGGER_EN
      .trig      (trig_v[g]),
`endif
      .busy      (busy_v[g])
    );
  end

  function automatic int bpc_of(input int i);
    case (i)
      0:       return 4;
      1:       return 1;
      2:       return 2;
      default: return 16;
    endcase
  endfunction

  // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // S-box from its definition: multiplicative inverse followed by the affine map.
  task automatic build_sbox();
    for (int v = 0; v < 256; v++) begin
      logic [7:0] inv, b;
      inv = 8'h00;
      for (int w = 1; w < 256; w++)
        if (gmul(8'(v), 8'(w)) == 8'h01) inv = 8'(w);
      b = inv;
      sbox_ref[v] = b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                      ^ {b[3:0], b[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] subbytes_ref(input logic [127:0] st);
    logic [127:0] r;
    for (int k = 0; k < 16; k++) r[8*k +: 8] = sbox_ref[st[8*k +: 8]];
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drives one block into instance i and reports what it observed; callers judge.
  task automatic run_block(input int i, input logic [127:0] st, input bit poke, input bit release_out,
                           output int lat, output logic [127:0] res, output int bad,
                           output int trig_cnt, output bit trig_first);
    int ns, k;
    ns = 16 / bpc_of(i);
    lat = -1; res = '0; bad = 0; trig_cnt = 0; trig_first = 1'b0;
    k = 0;
    @(negedge clk);
    while (!in_ready_v[i] && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready_v[i]) begin
      bad++;
      return;
    end
    state_in = st;
    in_valid_v[i] = 1'b1;
    for (k = 0; k < ns + 10; k++) begin
      @(negedge clk);
      if (k < ns && !(busy_v[i] === 1'b1 && in_ready_v[i] === 1'b0 && out_valid_v[i] === 1'b0))
        bad++;
`ifdef SUBBYTES_TRIGGER_EN
      if (trig_v[i] === 1'b1) begin
        trig_cnt++;
        if (k == 0) trig_first = 1'b1;
      end
`endif
      if (out_valid_v[i] === 1'b1) begin
        lat = k + 1;
        res = state_out_v[i];
        in_valid_v[i] = 1'b0;
        break;
      end
      in_valid_v[i] = poke & k[0];
      if (poke) state_in = rand128();
    end
    in_valid_v[i] = 1'b0;
    if (release_out && lat > 0) begin
      out_ready_v[i] = 1'b1;
      @(negedge clk);
      out_ready_v[i] = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_valid_v = '0;
    out_ready_v = '0;
    state_in = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid_v[i], in_ready_v[i], busy_v[i]} !== 3'b010) begin
        n_err++;
        $display("FAIL reset_flags[%0d]: got ov/ir/busy=%b want 010", i,
                 {out_valid_v[i], in_ready_v[i], busy_v[i]});
      end
      n_cmp++;
      if (state_out_v[i] !== 128'h0) begin
        n_err++;
        $display("FAIL reset_state_out[%0d]: got %h want 0", i, state_out_v[i]);
      end
`ifdef SUBBYTES_TRIGGER_EN
      n_cmp++;
      if (trig_v[i] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_trig[%0d]: got %b want 0", i, trig_v[i]);
      end
`endif
    end
    rst = 1'b0;
  endtask

  task automatic test_zero();
    int lat, bad, tc; bit tf; logic [127:0] res;
    run_block(0, 128'h0, 1'b0, 1'b1, lat, res, bad, tc, tf);
    n_cmp++;
    if (res !== {16{8'h63}}) begin
      n_err++;
      $display("FAIL zero_result: got %h want %h", res, {16{8'h63}});
    end
    n_cmp++;
    if (lat != 5) begin
      n_err++;
      $display("FAIL zero_latency: got %0d want 5", lat);
    end
  endtask

  task automatic test_fips();
    int lat, bad, tc; bit tf; logic [127:0] res;
    run_block(0, FIPS_IN, 1'b0, 1'b1, lat, res, bad, tc, tf);
    n_cmp++;
    if (res !== FIPS_OUT) begin
      n_err++;
      $display("FAIL fips_result: got %h want %h", res, FIPS_OUT);
    end
    n_cmp++;
    if (res !== subbytes_ref(FIPS_IN)) begin
      n_err++;
      $display("FAIL fips_model: got %h want %h", res, subbytes_ref(FIPS_IN));
    end
    n_cmp++;
    if (bad != 0) begin
      n_err++;
      $display("FAIL fips_busy_flags: got %0d bad cycles want 0", bad);
    end
  endtask

  task automatic test_random();
    int lat, bad, tc; bit tf; logic [127:0] res, st;
    for (int n = 0; n < 6; n++) begin
      st = rand128();
      run_block(0, st, 1'b0, 1'b1, lat, res, bad, tc, tf);
      n_cmp++;
      if (res !== subbytes_ref(st) || lat != 5) begin
        n_err++;
        $display("FAIL random_block[%0d]: got %h lat %0d want %h lat 5", n, res, lat, subbytes_ref(st));
      end
    end
  endtask

  task automatic test_backpressure();
    int lat, bad, tc, k; bit tf; logic [127:0] a, b, res;
    a = rand128();
    b = rand128();
    run_block(0, a, 1'b0, 1'b0, lat, res, bad, tc, tf);
    n_cmp++;
    if (res !== subbytes_ref(a)) begin
      n_err++;
      $display("FAIL bp_first_result: got %h want %h", res, subbytes_ref(a));
    end
    state_in = b;
    in_valid_v[0] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_cmp++;
      if (!(out_valid_v[0] === 1'b1 && in_ready_v[0] === 1'b0 && busy_v[0] === 1'b0 &&
            state_out_v[0] === subbytes_ref(a))) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got ov=%b ir=%b out=%h want ov=1 ir=0 out=%h",
                 c, out_valid_v[0], in_ready_v[0], state_out_v[0], subbytes_ref(a));
      end
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
    n_cmp++;
    if (!(out_valid_v[0] === 1'b0 && in_ready_v[0] === 1'b1 && busy_v[0] === 1'b0 &&
          state_out_v[0] === subbytes_ref(a))) begin
      n_err++;
      $display("FAIL bp_release_idle: got ov=%b ir=%b busy=%b out=%h want ov=0 ir=1 busy=0 out=%h",
               out_valid_v[0], in_ready_v[0], busy_v[0], state_out_v[0], subbytes_ref(a));
    end
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    n_cmp++;
    if (!(busy_v[0] === 1'b1 && in_ready_v[0] === 1'b0)) begin
      n_err++;
      $display("FAIL bp_next_accept: got busy=%b ir=%b want busy=1 ir=0", busy_v[0], in_ready_v[0]);
    end
    k = 0;
    while (out_valid_v[0] !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (out_valid_v[0] !== 1'b1 || state_out_v[0] !== subbytes_ref(b)) begin
      n_err++;
      $display("FAIL bp_next_result: got ov=%b out=%h want ov=1 out=%h",
               out_valid_v[0], state_out_v[0], subbytes_ref(b));
    end
    out_ready_v[0] = 1'b1;
    @(negedge clk);
    out_ready_v[0] = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    int lat, bad, tc; bit tf; logic [127:0] a, b, res;
    a = rand128();
    b = rand128();
    @(negedge clk);
    state_in = a;
    in_valid_v[0] = 1'b1;
    @(negedge clk);
    in_valid_v[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy_v[0] !== 1'b1) begin
      n_err++;
      $display("FAIL midrst_precondition: got busy=%b want 1", busy_v[0]);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if (!(out_valid_v[0] === 1'b0 && in_ready_v[0] === 1'b1 && busy_v[0] === 1'b0 &&
          state_out_v[0] === 128'h0)) begin
      n_err++;
      $display("FAIL midrst_state: got ov=%b ir=%b busy=%b out=%h want ov=0 ir=1 busy=0 out=0",
               out_valid_v[0], in_ready_v[0], busy_v[0], state_out_v[0]);
    end
    run_block(0, b, 1'b0, 1'b1, lat, res, bad, tc, tf);
    n_cmp++;
    if (res !== subbytes_ref(b) || lat != 5) begin
      n_err++;
      $display("FAIL midrst_after: got %h lat %0d want %h lat 5", res, lat, subbytes_ref(b));
    end
  endtask

  task automatic test_sweep();
    int lat, bad, tc, want_lat; bit tf; logic [127:0] res;
    for (int i = 1; i < 4; i++) begin
      want_lat = 16 / bpc_of(i) + 1;
      run_block(i, FIPS_IN, 1'b1, 1'b1, lat, res, bad, tc, tf);
      n_cmp++;
      if (res !== FIPS_OUT) begin
        n_err++;
        $display("FAIL sweep_result[bpc=%0d]: got %h want %h", bpc_of(i), res, FIPS_OUT);
      end
      n_cmp++;
      if (lat != want_lat) begin
        n_err++;
        $display("FAIL sweep_latency[bpc=%0d]: got %0d want %0d", bpc_of(i), lat, want_lat);
      end
      n_cmp++;
      if (bad != 0) begin
        n_err++;
        $display("FAIL sweep_busy_ignore[bpc=%0d]: got %0d bad cycles want 0", bpc_of(i), bad);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] q [$];
    logic [127:0] want;
    int last_acc, got;
    bit prev_busy;
    state_in = rand128();
    in_valid_v[0] = 1'b1;
    out_ready_v[0] = 1'b1;
    prev_busy = 1'b0;
    got = 0;
    last_acc = -1;
    for (int cyc = 0; cyc < 60 && got < 3; cyc++) begin
      @(negedge clk);
      if (out_valid_v[0] === 1'b1) begin
        want = (q.size() > 0) ? q.pop_front() : 128'hx;
        n_cmp++;
        if (state_out_v[0] !== want) begin
          n_err++;
          $display("FAIL b2b_result[%0d]: got %h want %h", got, state_out_v[0], want);
        end
        got++;
        if (got == 3) in_valid_v[0] = 1'b0;
      end
      if (busy_v[0] === 1'b1 && !prev_busy) begin
        q.push_back(subbytes_ref(state_in));
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc != 6) begin
            n_err++;
            $display("FAIL b2b_period: got %0d cycles want 6", cyc - last_acc);
          end
        end
        last_acc = cyc;
        state_in = rand128();
      end
      prev_busy = busy_v[0];
    end
    n_cmp++;
    if (got != 3) begin
      n_err++;
      $display("FAIL b2b_timeout: got %0d blocks want 3", got);
    end
    in_valid_v[0] = 1'b0;
    repeat (3) @(negedge clk);
    out_ready_v[0] = 1'b0;
  endtask

`ifdef SUBBYTES_TRIGGER_EN
  task automatic test_trigger();
    int lat, bad, tc; bit tf; logic [127:0] res;
    for (int i = 0; i < 4; i++) begin
      run_block(i, rand128(), 1'b0, 1'b1, lat, res, bad, tc, tf);
      n_cmp++;
      if (tc != 1 || !tf) begin
        n_err++;
        $display("FAIL trig_pulse[bpc=%0d]: got count %0d first %0d want count 1 first 1", bpc_of(i), tc, tf);
      end
    end
  endtask
`endif

  initial begin
    rst = 1'b1;
    in_valid_v = '0;
    out_ready_v = '0;
    state_in = '0;
    build_sbox();
    test_reset();
    test_zero();
    test_fips();
    test_random();
    test_backpressure();
    test_reset_mid_busy();
    test_sweep();
    test_back_to_back();
`ifdef SUBBYTES_TRIGGER_EN
    test_trigger();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
